// File: rtl/vxe_fifo_pkg.sv
// Shared constants and helpers for the vxe_fifo slice.
// The default data width matches the vxe_reg consumer.
package vxe_fifo_pkg;

  localparam int VXE_DATA_WIDTH = 32;

  // Handshake outcome for one cycle, after the full/empty gating is applied.
  typedef struct packed {
    logic push_ok;
    logic pop_ok;
  } vxe_fifo_req_t;

  function automatic int vxe_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/vxe_fifo_mem.sv
// Storage for vxe_fifo: DEPTH x DATA_WIDTH register rows.
// One write port and one asynchronous read port. The rows are not reset.
module vxe_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_POW2 = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_POW2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DEPTH_POW2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << DEPTH_POW2;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] row_bus;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_row
      logic [DATA_WIDTH-1:0] row_reg;

      always_ff @(posedge clk) begin
        if (we && (waddr == DEPTH_POW2'(gi))) begin
          row_reg <= wdata;
        end
      end

      assign row_bus[gi] = row_reg;
    end
  endgenerate

  // The head word is visible without a read-latency bubble.
  assign rdata = row_bus[raddr];

endmodule

// File: rtl/vxe_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers.
// empty, full and count are derived only from the pointer registers.
module vxe_fifo
  import vxe_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = VXE_DATA_WIDTH,
  parameter int DEPTH_POW2 = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  enqueue,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  dequeue,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_POW2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_POW2;
  localparam int PW    = vxe_clog2(DEPTH) + 1;

  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [DATA_WIDTH-1:0] head_word;
  vxe_fifo_req_t         req;

  assign req.push_ok = enqueue && !full;
  assign req.pop_ok  = dequeue && !empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (req.push_ok) wr_ptr_next = wr_ptr_reg + PW'(1);
    if (req.pop_ok)  rd_ptr_next = rd_ptr_reg + PW'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // The wrap bit tells a full ring apart from an empty one.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                 (wr_ptr_reg[PW-2:0] == rd_ptr_reg[PW-2:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;

  vxe_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_POW2 (DEPTH_POW2)
  ) u_mem (
    .clk   (clk),
    .we    (req.push_ok),
    .waddr (wr_ptr_reg[PW-2:0]),
    .wdata (data_in),
    .raddr (rd_ptr_reg[PW-2:0]),
    .rdata (head_word)
  );

  assign data_out = empty ? '0 : head_word;

endmodule

// File: tb/tb_vxe_fifo.sv
// Self-checking bench for vxe_fifo: vector table, hand sequences, and a
// random push/pop run on a 2-entry instance against a queue model.
module tb_vxe_fifo;

  logic        clk;
  logic        nrst;
  logic        enq, deq;
  logic [31:0] din;
  logic [31:0] dout;
  logic        emp, ful;
  logic [2:0]  cnt;

  logic        enq1, deq1;
  logic [31:0] din1;
  logic [31:0] dout1;
  logic        emp1, ful1;
  logic [1:0]  cnt1;

  int total = 0;
  int bad   = 0;

  vxe_fifo #(.DATA_WIDTH(32), .DEPTH_POW2(2)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .enqueue  (enq),
    .data_in  (din),
    .dequeue  (deq),
    .data_out (dout),
    .empty    (emp),
    .full     (ful),
    .count    (cnt)
  );

  vxe_fifo #(.DATA_WIDTH(32), .DEPTH_POW2(1)) dut1 (
    .clk      (clk),
    .nrst     (nrst),
    .enqueue  (enq1),
    .data_in  (din1),
    .dequeue  (deq1),
    .data_out (dout1),
    .empty    (emp1),
    .full     (ful1),
    .count    (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        enq;
    logic        deq;
    logic [31:0] din;
    int          cnt;
    logic        emp;
    logic        ful;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_main(input string name, input int c, input logic e, input logic f,
                          input logic [31:0] d);
    chk({name, ".count"}, 32'(cnt), 32'(c));
    chk({name, ".empty"}, 32'(emp), 32'(e));
    chk({name, ".full"},  32'(ful), 32'(f));
    chk({name, ".data"},  dout, d);
  endtask

  // Drive at the negedge, let one posedge happen, sample at the next negedge.
  task automatic step(input logic e, input logic d, input logic [31:0] w);
    enq = e; deq = d; din = w;
    @(posedge clk);
    @(negedge clk);
    enq = 1'b0; deq = 1'b0;
  endtask

  logic [31:0] q[$];
  logic [31:0] q1[$];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h0,          0, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'hfefe_0000,  1, 1'b0, 1'b0, 32'hfefe_0000};
    vecs[2]  = '{1'b1, 1'b0, 32'hfefe_0001,  2, 1'b0, 1'b0, 32'hfefe_0000};
    vecs[3]  = '{1'b1, 1'b0, 32'hfefe_0002,  3, 1'b0, 1'b0, 32'hfefe_0000};
    vecs[4]  = '{1'b1, 1'b0, 32'hfefe_0003,  4, 1'b0, 1'b1, 32'hfefe_0000};
    vecs[5]  = '{1'b1, 1'b0, 32'hdead_beef,  4, 1'b0, 1'b1, 32'hfefe_0000};
    vecs[6]  = '{1'b0, 1'b1, 32'h0,          3, 1'b0, 1'b0, 32'hfefe_0001};
    vecs[7]  = '{1'b0, 1'b1, 32'h0,          2, 1'b0, 1'b0, 32'hfefe_0002};
    vecs[8]  = '{1'b0, 1'b1, 32'h0,          1, 1'b0, 1'b0, 32'hfefe_0003};
    vecs[9]  = '{1'b0, 1'b1, 32'h0,          0, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 32'hbebe_0000,  1, 1'b0, 1'b0, 32'hbebe_0000};
    vecs[11] = '{1'b1, 1'b0, 32'hbebe_0001,  2, 1'b0, 1'b0, 32'hbebe_0000};
    vecs[12] = '{1'b1, 1'b0, 32'hbebe_0002,  3, 1'b0, 1'b0, 32'hbebe_0000};
    vecs[13] = '{1'b1, 1'b0, 32'hbebe_0003,  4, 1'b0, 1'b1, 32'hbebe_0000};
    vecs[14] = '{1'b1, 1'b1, 32'hcafe_0000,  3, 1'b0, 1'b0, 32'hbebe_0001};
    vecs[15] = '{1'b0, 1'b1, 32'h0,          2, 1'b0, 1'b0, 32'hbebe_0002};
    vecs[16] = '{1'b0, 1'b1, 32'h0,          1, 1'b0, 1'b0, 32'hbebe_0003};
    vecs[17] = '{1'b0, 1'b1, 32'h0,          0, 1'b1, 1'b0, 32'h0};

    nrst = 1'b0;
    enq = 1'b0; deq = 1'b0; din = '0;
    enq1 = 1'b0; deq1 = 1'b0; din1 = '0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    chk_main("reset", 0, 1'b1, 1'b0, 32'h0);
    chk("reset.small_empty", 32'(emp1), 32'd1);

    // Table: idle dequeue, fill/overflow/drain, both-at-empty, both-at-full.
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].enq, vecs[i].deq, vecs[i].din);
      chk_main($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].dout);
      $display("vec %0d enq=%0b deq=%0b din=%h -> count=%0d data_out=%h",
               i, vecs[i].enq, vecs[i].deq, vecs[i].din, cnt, dout);
    end

    // Steady two-entry occupancy with simultaneous push and pop.
    q.delete();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h1000_0000 + 32'(i));
      q.push_back(32'h1000_0000 + 32'(i));
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stream%0d.data", i), dout, q[0]);
      step(1'b1, 1'b1, 32'h1000_0002 + 32'(i));
      void'(q.pop_front());
      q.push_back(32'h1000_0002 + 32'(i));
      chk($sformatf("stream%0d.count", i), 32'(cnt), 32'd2);
      $display("stream %0d push=%h -> count=%0d data_out=%h", i, 32'h1000_0002 + 32'(i), cnt, dout);
    end
    chk("stream.tail", dout, q[0]);

    // Asynchronous reset with entries stored.
    step(1'b1, 1'b0, 32'h2000_0000);
    chk("prereset.count", 32'(cnt), 32'd3);
    #2;
    nrst = 1'b0;
    #1;
    chk_main("async_reset", 0, 1'b1, 1'b0, 32'h0);
    $display("async reset -> count=%0d empty=%0b data_out=%h", cnt, emp, dout);
    @(negedge clk);
    nrst = 1'b1;
    step(1'b1, 1'b0, 32'h3333_4444);
    chk_main("post_reset_push", 1, 1'b0, 1'b0, 32'h3333_4444);
    step(1'b0, 1'b1, 32'h0);
    chk_main("post_reset_pop", 0, 1'b1, 1'b0, 32'h0);

    // Random push/pop on the two-entry instance.
    q1.delete();
    for (int i = 0; i < 1000; i++) begin
      logic e, d, pushed, popped;
      logic [31:0] w;
      e = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      w = $urandom;
      enq1 = e; deq1 = d; din1 = w;
      @(posedge clk);
      @(negedge clk);
      enq1 = 1'b0; deq1 = 1'b0;
      pushed = e && (q1.size() < 2);
      popped = d && (q1.size() > 0);
      if (popped) void'(q1.pop_front());
      if (pushed) q1.push_back(w);
      chk($sformatf("rand%0d.count", i), 32'(cnt1), 32'(q1.size()));
      chk($sformatf("rand%0d.data", i), dout1, (q1.size() > 0) ? q1[0] : 32'h0);
      chk($sformatf("rand%0d.empty", i), 32'(emp1), 32'(q1.size() == 0));
      chk($sformatf("rand%0d.full", i), 32'(ful1), 32'(q1.size() == 2));
      chk($sformatf("rand%0d.exclusive", i), 32'(emp1 && ful1), 32'd0);
      $display("rand %0d enq=%0b deq=%0b -> count=%0d data_out=%h", i, e, d, cnt1, dout1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
